// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered R-type ALU with iterative 1-bit/cycle shifts; valid/ready in (in_valid/in_ready) and out (out_valid/out_ready), result/rd_addr_out/reg_write_out to write-back, busy while shifting
module alu_exec_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALU_control,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  register_write_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res;
  logic [4:0] cnt_q, cnt_d, shamt;
  logic [3:0] op_q, op_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic we_q, we_d, accept, is_shift;
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign shamt = operand_b[4:0];
  assign is_shift = ALU_control == 4'd5 || ALU_control == 4'd6 || ALU_control == 4'd7;
  always_comb
    alu_res = ALU_control == 4'd0 ? operand_a + operand_b :
              ALU_control == 4'd1 ? operand_a - operand_b :
              ALU_control == 4'd2 ? operand_a & operand_b :
              ALU_control == 4'd3 ? operand_a | operand_b :
              ALU_control == 4'd4 ? operand_a ^ operand_b :
              ALU_control == 4'd8 ? {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)} :
              ALU_control == 4'd9 ? {{(XLEN-1){1'b0}}, operand_a < operand_b} :
              is_shift ? operand_a : '0;
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    we_d     = we_q;
    if (accept) begin
      state_d  = is_shift && shamt != 5'd0 ? SHIFT : DONE;
      result_d = alu_res;
      cnt_d    = is_shift ? shamt : 5'd0;
      op_d     = ALU_control;
      rd_d     = rd_addr;
      we_d     = register_write_enable && ALU_control < 4'd10;
    end else if (state_q == SHIFT) begin
      result_d = op_q == 4'd5 ? result_q << 1 :
                 op_q == 4'd6 ? result_q >> 1 : {result_q[XLEN-1], result_q[XLEN-1:1]};
      cnt_d    = cnt_q - 5'd1;
      state_d  = cnt_q == 5'd1 ? DONE : SHIFT;
    end else if (state_q == DONE && out_ready) begin
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
    end
  end
  assign out_valid     = state_q == DONE;
  assign busy          = state_q == SHIFT;
  assign result        = result_q;
  assign rd_addr_out   = rd_q;
  assign reg_write_out = out_valid && we_q && rd_q != '0;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: table-driven and scoreboard-checked bench for alu_exec_stage
module tb_alu_exec_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, register_write_enable = 0;
  logic in_ready, out_valid, reg_write_out, busy;
  logic [3:0] ALU_control = 0;
  logic [31:0] operand_a = 0, operand_b = 0, result;
  logic [4:0] rd_addr = 0, rd_addr_out;
  typedef struct {
    logic [3:0] code; logic [31:0] a, b; logic [4:0] rd; logic we;
    logic [31:0] res; logic ewe; int lat;
  } vec_t;
  typedef struct {logic [31:0] res; logic [4:0] rd; logic we; int acc, lat;} exp_t;
  exp_t q[$];
  vec_t vt[15];
  int tests = 0, fails = 0, cyc = 0, first_cyc = 0, nb, nv;
  bit seen = 0;
  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_control(ALU_control), .operand_a(operand_a), .operand_b(operand_b),
    .rd_addr(rd_addr), .register_write_enable(register_write_enable),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic send(vec_t v);
    int n = 0;
    in_valid = 1; ALU_control = v.code; operand_a = v.a; operand_b = v.b;
    rd_addr = v.rd; register_write_enable = v.we;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      fails++; tests++;
      $display("FAIL accept_timeout: in_ready stuck at 0 expected 1");
    end else q.push_back('{v.res, v.rd, v.ewe, cyc, v.lat});
    @(posedge clk); #1;
    in_valid = 0; operand_a = $urandom; operand_b = $urandom;
    ALU_control = 4'($urandom); rd_addr = 5'($urandom); register_write_enable = 1'($urandom);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    chk("drain_pending", q.size(), 0);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (!seen) begin seen = 1; first_cyc = cyc; end
      if (out_ready) begin
        if (q.size() == 0) begin
          fails++; tests++;
          $display("FAIL spurious_output: result %h with no op outstanding", result);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("rd_addr_out", 32'(rd_addr_out), 32'(e.rd));
          chk("reg_write_out", 32'(reg_write_out), 32'(e.we));
          chk("latency", first_cyc - e.acc, e.lat);
        end
        seen = 0;
      end
    end else seen = 0;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0]  = '{4'd0, 32'h7FFFFFFF, 32'h1, 5'd3, 1'b1, 32'h80000000, 1'b1, 1};
    vt[1]  = '{4'd1, 32'h5, 32'h7, 5'd4, 1'b1, 32'hFFFFFFFE, 1'b1, 1};
    vt[2]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd5, 1'b1, 32'h00F000F0, 1'b1, 1};
    vt[3]  = '{4'd3, 32'h12340000, 32'h00005678, 5'd6, 1'b1, 32'h12345678, 1'b1, 1};
    vt[4]  = '{4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 5'd7, 1'b1, 32'hF0F00F0F, 1'b1, 1};
    vt[5]  = '{4'd5, 32'h1234, 32'h20, 5'd8, 1'b1, 32'h1234, 1'b1, 1};
    vt[6]  = '{4'd8, 32'hFFFFFFFF, 32'h1, 5'd9, 1'b1, 32'h1, 1'b1, 1};
    vt[7]  = '{4'd9, 32'hFFFFFFFF, 32'h1, 5'd10, 1'b1, 32'h0, 1'b1, 1};
    vt[8]  = '{4'd10, 32'h11, 32'h22, 5'd11, 1'b1, 32'h0, 1'b0, 1};
    vt[9]  = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 1'b1, 32'h0, 1'b0, 1};
    vt[10] = '{4'd5, 32'h1, 32'd31, 5'd13, 1'b1, 32'h80000000, 1'b1, 32};
    vt[11] = '{4'd6, 32'h80000000, 32'd3, 5'd14, 1'b1, 32'h10000000, 1'b1, 4};
    vt[12] = '{4'd7, 32'h80000010, 32'd4, 5'd15, 1'b1, 32'hF8000001, 1'b1, 5};
    vt[13] = '{4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b1, 32'h0, 1'b0, 1};
    vt[14] = '{4'd1, 32'h0, 32'h1, 5'd16, 1'b0, 32'hFFFFFFFF, 1'b0, 1};
    in_valid = 1; ALU_control = 4'd0; operand_a = 32'h5; operand_b = 32'h6; rd_addr = 5'd1;
    register_write_enable = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_reg_write", 32'(reg_write_out), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    in_valid = 0; rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid_after", 32'(out_valid), 0);
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) send(vt[i]);
    drain();
    send('{4'd7, 32'h80000010, 32'd4, 5'd2, 1'b1, 32'hF8000001, 1'b1, 5});
    nb = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("sra_busy_cycles", nb, 4);
    drain();
    out_ready = 0;
    send('{4'd0, 32'd10, 32'd20, 5'd0, 1'b1, 32'd30, 1'b0, 1});
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_result", result, 32'd30);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_reg_write", 32'(reg_write_out), 0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    drain();
    send('{4'd6, 32'hFFFF0000, 32'd20, 5'd9, 1'b1, 32'h00000FFF, 1'b1, 21});
    @(posedge clk); #1;
    rst_n = 0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) nv++;
    end
    chk("no_output_after_reset", nv, 0);
    @(posedge clk); #1;
    send('{4'd0, 32'd2, 32'd3, 5'd1, 1'b1, 32'd5, 1'b1, 1});
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
